ram_arbiter: RTL and testbench

Shares the CPU's single-port 256×16 RAM among several requesters: instruction fetch, data load/store, and the program loader that replaces direct RAM pokes from the bench. Arbitration is round-robin, with an optional lock for loader bursts. A hold-limit counter bounds any lock so no requester starves. Sits between the CPU core/loader and the `ram` instance in `cpu`.

---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/ram_arbiter_if.sv | 33 +++
 rtl/rr_pick.sv | 29 ++
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared memory-system constants for the CPU, its RAM, the loader and the RAM arbiter.
// Also carries the arbiter's observable state record.
package cpu_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int N_REQ  = 3;

  localparam int PORT_LOADER = 0;
  localparam int PORT_DATA   = 1;
  localparam int PORT_FETCH  = 2;

  localparam int LAST_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Snapshot of the arbiter registers; hold_cnt is zero-extended to a fixed width.
  typedef struct packed {
    logic [LAST_W-1:0] last;
    logic [LAST_W-1:0] owner;
    logic              locked;
    logic [7:0]        hold_cnt;
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus of the RAM arbiter.
// Handshake: port i's access is accepted in the cycle where req[i] & gnt[i]; req (and
// its we/addr/wdata) is held until then, gnt is zero-latency, and a read answers with
// rvalid[i] plus rdata exactly one cycle after the accept edge; writes have no response.
interface ram_arbiter_if #(
  parameter int N_REQ  = cpu_mem_pkg::N_REQ,
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req, lock, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, lock, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requesting port strictly after last,
// searching upward and wrapping, so last itself has the lowest priority.
module rr_pick #(
  parameter int N  = 3,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  sel,
  output logic          any
);

  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int            idx;
      logic [LW-1:0] ix;
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      ix = LW'(idx);
      if (!any && req[ix]) begin
        sel[ix] = 1'b1;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port RAM between loader, data and fetch ports,
// with a lock for bursts that a hold-limit counter bounds to MAX_LOCK consecutive grants.
module ram_arbiter #(
  parameter int N_REQ    = cpu_mem_pkg::N_REQ,
  parameter int ADDR_W   = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W   = cpu_mem_pkg::DATA_W,
  parameter int MAX_LOCK = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  ram_arbiter_if.slave            bus,
  output cpu_mem_pkg::arb_state_t dbg
);
  import cpu_mem_pkg::*;

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_LOCK) + 1;

  logic [LW-1:0]    last_q;
  logic [LW-1:0]    owner_q;
  logic             locked_q;
  logic [HW-1:0]    hold_q;
  logic [N_REQ-1:0] rv_q;

  logic [N_REQ-1:0] rr_sel;
  logic             rr_any;
  logic [N_REQ-1:0] sel;
  logic             any;
  logic [LW-1:0]    g;
  logic             hold_ok;

  rr_pick #(.N(N_REQ), .LW(LW)) u_pick (
    .req  (bus.req),
    .last (last_q),
    .sel  (rr_sel),
    .any  (rr_any)
  );

  // Owner keeps priority only while it still requests and is under the hold limit.
  assign hold_ok = locked_q && bus.req[owner_q] && (hold_q < HW'(MAX_LOCK));

  always_comb begin
    sel = rr_sel;
    any = rr_any;
    if (hold_ok) begin
      sel          = '0;
      sel[owner_q] = 1'b1;
      any          = 1'b1;
    end
    g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel[i]) g = LW'(i);
    end
  end

  always_comb begin
    bus.gnt       = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rvalid    = '0;
    bus.rdata     = '0;
    if (!reset) begin
      if (any) begin
        bus.gnt       = sel;
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.we[g];
        bus.mem_addr  = bus.addr[g*ADDR_W +: ADDR_W];
        bus.mem_wdata = bus.wdata[g*DATA_W +: DATA_W];
      end
      bus.rvalid = rv_q;
      if (rv_q != '0) bus.rdata = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= LW'(N_REQ - 1);
      owner_q  <= '0;
      locked_q <= 1'b0;
      hold_q   <= '0;
      rv_q     <= '0;
    end else if (any) begin
      last_q <= g;
      if (bus.lock[g]) begin
        // A grant won through the lock continues the streak; any other grant starts one.
        owner_q  <= g;
        locked_q <= 1'b1;
        hold_q   <= hold_ok ? hold_q + HW'(1) : HW'(1);
      end else begin
        locked_q <= 1'b0;
        hold_q   <= '0;
      end
      rv_q <= bus.we[g] ? '0 : sel;
    end else begin
      locked_q <= 1'b0;
      hold_q   <= '0;
      rv_q     <= '0;
    end
  end

  always_comb begin
    dbg          = '0;
    dbg.last     = LAST_W'(last_q);
    dbg.owner    = LAST_W'(owner_q);
    dbg.locked   = locked_q;
    dbg.hold_cnt = 8'(hold_q);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic, each
// cycle compared with a rule-level reference model and a read-data scoreboard.
module tb_ram_arbiter;
  localparam int MAX_LOCK = 4;

  logic clk;
  logic reset;
  cpu_mem_pkg::arb_state_t dbg;

  ram_arbiter_if #(.N_REQ(3), .ADDR_W(8), .DATA_W(16)) bus ();

  ram_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(16), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbg   (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (write-first, 1-cycle read) ----------------
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata     <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int m_last;
  int m_owner;
  bit m_locked;
  int m_hold;
  logic [2:0]  m_rv;
  logic [15:0] shadow [256];
  logic [15:0] exp_q[$];

  logic [2:0]  obs_gnt;
  logic [2:0]  obs_rvalid;
  logic [15:0] obs_rdata;

  function automatic int model_pick(input logic [2:0] r);
    if (m_locked && r[m_owner] && m_hold < MAX_LOCK) return m_owner;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (m_last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last   = 2;
    m_owner  = 0;
    m_locked = 0;
    m_hold   = 0;
    m_rv     = '0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                       input logic [23:0] a, input logic [47:0] d);
    int          g;
    logic [2:0]  eg;
    logic [15:0] erd;
    bus.req   = r;
    bus.lock  = l;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    g  = model_pick(r);
    eg = (g < 0) ? 3'b000 : 3'(1 << g);
    obs_gnt    = bus.gnt;
    obs_rvalid = bus.rvalid;
    obs_rdata  = bus.rdata;
    n_tests++;
    if (bus.gnt !== eg) begin
      n_fail++;
      $display("FAIL gnt: got %b expected %b (req %b)", bus.gnt, eg, r);
    end
    n_tests++;
    if (bus.mem_en !== (g >= 0)) begin
      n_fail++;
      $display("FAIL mem_en: got %b expected %b", bus.mem_en, (g >= 0));
    end
    if (g >= 0) begin
      n_tests++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {w[g], a[g*8 +: 8], d[g*16 +: 16]}) begin
        n_fail++;
        $display("FAIL mem_cmd: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata, w[g], a[g*8 +: 8], d[g*16 +: 16]);
      end
    end
    n_tests++;
    if (bus.rvalid !== m_rv) begin
      n_fail++;
      $display("FAIL rvalid: got %b expected %b", bus.rvalid, m_rv);
    end
    erd = 16'h0000;
    if (m_rv != 3'b000 && exp_q.size() > 0) erd = exp_q.pop_front();
    n_tests++;
    if (bus.rdata !== erd) begin
      n_fail++;
      $display("FAIL rdata: got %h expected %h", bus.rdata, erd);
    end
    @(posedge clk);
    if (g >= 0) begin
      bit streak;
      streak = m_locked && m_owner == g && m_hold < MAX_LOCK;
      m_last = g;
      if (l[g]) begin
        m_hold   = streak ? m_hold + 1 : 1;
        m_owner  = g;
        m_locked = 1;
      end else begin
        m_locked = 0;
        m_hold   = 0;
      end
      if (w[g]) begin
        shadow[a[g*8 +: 8]] = d[g*16 +: 16];
        m_rv = 3'b000;
      end else begin
        m_rv = 3'(1 << g);
        exp_q.push_back(shadow[a[g*8 +: 8]]);
      end
    end else begin
      m_locked = 0;
      m_hold   = 0;
      m_rv     = 3'b000;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rvalid, bus.rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got gnt=%b en=%b we=%b addr=%h wdata=%h rvalid=%b rdata=%h expected all 0",
                 bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rvalid, bus.rdata);
      end
      if (i == 1) begin
        n_tests++;
        if (dbg.last !== 2'd2 || dbg.locked !== 1'b0 || dbg.hold_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL reset_state: got last=%0d locked=%b hold=%0d expected 2 0 0",
                   dbg.last, dbg.locked, dbg.hold_cnt);
        end
      end
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req = 3'b111; bus.lock = 3'b111; bus.we = 3'b000;
    bus.addr = 24'h030201; bus.wdata = '0;
    do_reset();
    cycle(3'b111, 3'b000, 3'b000, 24'h000000, 48'h0);
    n_tests++;
    if (obs_gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL first_grant: got %b expected 001", obs_gnt);
    end
  endtask

  task automatic test_reset_mid_traffic();
    cycle(3'b111, 3'b000, 3'b000, 24'h050403, 48'h0);
    cycle(3'b111, 3'b000, 3'b000, 24'h050403, 48'h0);
    do_reset();
    cycle(3'b111, 3'b000, 3'b000, 24'h050403, 48'h0);
    n_tests++;
    if (obs_gnt !== 3'b001 || obs_rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_traffic: got gnt=%b rvalid=%b expected 001 000", obs_gnt, obs_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) cycle(3'b111, 3'b000, 3'b000, {8'($urandom), 8'($urandom), 8'($urandom)}, 48'h0);
      else       cycle(3'b000, 3'b000, 3'b000, 24'h0, 48'h0);
      if (i < 6) begin
        n_tests++;
        if (obs_gnt !== seq[i]) begin
          n_fail++;
          $display("FAIL rr_gnt[%0d]: got %b expected %b", i, obs_gnt, seq[i]);
        end
      end
      if (i > 0) begin
        n_tests++;
        if (obs_rvalid !== seq[i-1]) begin
          n_fail++;
          $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, obs_rvalid, seq[i-1]);
        end
      end
    end
  endtask

  task automatic test_loader_burst();
    logic [15:0] vals [4] = '{16'h4001, 16'h4401, 16'h8003, 16'hF105};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(3'b101, 3'b001, 3'b001, {8'h00, 8'h00, 8'(i)}, {16'h0, 16'h0, vals[i]});
      n_tests++;
      if (obs_gnt !== 3'b001) begin
        n_fail++;
        $display("FAIL burst_gnt[%0d]: got %b expected 001", i, obs_gnt);
      end
    end
    cycle(3'b100, 3'b000, 3'b000, 24'h000000, 48'h0);
    n_tests++;
    if (obs_gnt !== 3'b100) begin
      n_fail++;
      $display("FAIL burst_fetch_gnt: got %b expected 100", obs_gnt);
    end
    cycle(3'b000, 3'b000, 3'b000, 24'h0, 48'h0);
    n_tests++;
    if (obs_rvalid !== 3'b100 || obs_rdata !== 16'h4001) begin
      n_fail++;
      $display("FAIL burst_fetch_read: got rvalid=%b rdata=%h expected 100 4001", obs_rvalid, obs_rdata);
    end
  endtask

  task automatic test_hold_limit();
    logic [2:0] eg;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(3'b011, 3'b001, 3'b000, {8'h00, 8'($urandom), 8'($urandom)}, 48'h0);
      eg = (i == 4 || i == 9) ? 3'b010 : 3'b001;
      n_tests++;
      if (obs_gnt !== eg) begin
        n_fail++;
        $display("FAIL hold_gnt[cycle %0d]: got %b expected %b", i + 1, obs_gnt, eg);
      end
    end
  endtask

  task automatic test_read_after_write();
    cycle(3'b010, 3'b000, 3'b010, {8'h00, 8'h09, 8'h00}, {16'h0, 16'h00AB, 16'h0});
    n_tests++;
    if (obs_gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL raw_write_gnt: got %b expected 010", obs_gnt);
    end
    cycle(3'b100, 3'b000, 3'b000, {8'h09, 8'h00, 8'h00}, 48'h0);
    cycle(3'b000, 3'b000, 3'b000, 24'h0, 48'h0);
    n_tests++;
    if (obs_rvalid !== 3'b100 || obs_rdata !== 16'h00AB) begin
      n_fail++;
      $display("FAIL raw_read: got rvalid=%b rdata=%h expected 100 00ab", obs_rvalid, obs_rdata);
    end
  endtask

  task automatic test_idle();
    int last_before;
    last_before = m_last;
    for (int i = 0; i < 5; i++) begin
      cycle(3'b000, 3'($urandom), 3'($urandom), 24'($urandom), 48'h0);
      n_tests++;
      if (obs_gnt !== 3'b000 || (i > 0 && obs_rvalid !== 3'b000)) begin
        n_fail++;
        $display("FAIL idle[%0d]: got gnt=%b rvalid=%b expected 000 000", i, obs_gnt, obs_rvalid);
      end
    end
    n_tests++;
    if (int'(dbg.last) !== last_before) begin
      n_fail++;
      $display("FAIL idle_last: got %0d expected %0d", dbg.last, last_before);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic [2:0] l;
    logic [23:0] a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 3; b++) begin
        r[b] = ($urandom_range(0, 3) != 0);
        l[b] = ($urandom_range(0, 1) != 0);
        a[b*8 +: 8] = 8'($urandom_range(0, 15));
      end
      cycle(r, l, 3'($urandom), a, {16'($urandom), 16'($urandom), 16'($urandom)});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'($urandom);
      shadow[i] = ram[i];
    end
    reset     = 1'b1;
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    model_reset();
    test_reset();
    test_reset_mid_traffic();
    test_round_robin();
    test_loader_burst();
    test_hold_limit();
    test_read_after_write();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
